gpu_uniform_loader: RTL and testbench
=====================================

// Module: gpu_uniform_loader
// PURPOSE
//  Command-stream controller that configures gpu_uniforms (4x4 matrix m00..m33, vp_width/vp_height).
//  Parses header+data words from the host command FIFO and issues single-cycle we/addr/data writes.
//  Interlocks with the pipeline front-end so uniforms never change while primitives are in flight.
// PARAMETERS
//  W         32        uniform data width
//  AW        8         uniform address width
//  MAX_ADDR  8'h11     highest valid uniform address
//  FX_ONE    32'h10000 Q16.16 1.0, used by LOAD_IDENTITY
// PORTS
//  CLK        in   1   clock
//  rst        in   1   synchronous reset, active-high
//  cmd_valid  in   1   command word valid
//  cmd_ready  out  1   command word accepted when valid&ready
//  cmd_data   in   32  header or data word
//  pipe_busy  in   1   pipeline front-end has primitives in flight
//  uni_lock   out  1   front-end must not start new primitives
//  u_we       out  1   uniform write strobe, one cycle per write
//  u_addr     out  AW  uniform address: r*4+c for m[r][c]; 0x10 vp_width; 0x11 vp_height
//  u_data     out  W   uniform write data; viewport uses [15:0]
//  busy       out  1   FSM not in IDLE
//  err        out  1   sticky: bad opcode or out-of-range address
//  err_clr    in   1   clears err
//  cmd_count  out  16  completed commands (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1, uni_lock=0, u_we=0, u_addr=0, u_data=0, busy=0, err=0, cmd_count=0.
//  Reset mid-command returns to IDLE at once; writes already issued are not undone.
//  Header: [31:28] op, [27:16] reserved (ignored), [15:8] base, [7:0] count.
//  Ops: 0 NOP; 1 WRITE_BLOCK; 2 SET_VIEWPORT; 3 LOAD_IDENTITY; others set err and are consumed as NOP.
//  WRITE_BLOCK with count=0 behaves as NOP. NOP does not assert uni_lock.
//  States: IDLE -> WAIT_IDLE -> {DATA | VP | IDENT} -> DONE -> IDLE.
//   IDLE: cmd_ready=1. Accepting a non-NOP header latches op/base/count and goes to WAIT_IDLE.
//   WAIT_IDLE: uni_lock=1, cmd_ready=0. Leave when pipe_busy=0 (same-cycle sample).
//   DATA: cmd_ready=1. Each accepted word writes addr base+i. Leave after the count-th word.
//   VP: cmd_ready=1. Accept one word; write 0x10<=[15:0], then 0x11<=[31:16] on consecutive cycles.
//   IDENT: cmd_ready=0. 16 consecutive writes, addr 0..15; FX_ONE when addr[1:0]==addr[3:2], else 0.
//   DONE: one cycle; uni_lock drops on the next cycle; cmd_count increments.
//  Outputs u_we/u_addr/u_data are registered; a write appears 1 cycle after data acceptance.
//  Invalid-cycle gaps in cmd_valid stall DATA/VP with no write.
//  Address increments in AW bits. A write to an address > MAX_ADDR is suppressed (u_we=0) and sets err.
//  The data word is still consumed, so the stream stays aligned.
//  err_clr and a new error in the same cycle: err stays 1.
//  pipe_busy rising after lock is taken is ignored; the pipeline must honour uni_lock.
// CONFIGURATION
//  UNIFORM_LOADER_STATS_EN defined: cmd_count counts completed non-NOP commands, wraps at 16'hFFFF->0.
//  Undefined: cmd_count tied to 0; no counter logic.
// TESTING
//  1. Release rst -> cmd_ready=1, uni_lock=0, u_we=0, err=0, busy=0.
//  2. Send 0x10000503 then data A,B,C with gaps.
//     -> u_we at addr 05,06,07 with A,B,C, each 1 cycle after acceptance; lock high throughout.
//  3. pipe_busy=1 when header 0x30000000 arrives.
//     -> uni_lock=1, cmd_ready=0, no writes until pipe_busy=0.
//     -> then 16 back-to-back writes: 0x10000 at addr 0,5,10,15, else 0.
//  4. Send 0x20000000, then 0x00F00140 -> write 0x10<=0x0140, next cycle 0x11<=0x00F0, then IDLE.
//  5. Send 0x10001003 + 3 words -> writes at 0x10 and 0x11; third word consumed with u_we=0.
//     -> err=1; err_clr pulse -> err=0.
//  6. Assert rst during IDENT at the 5th write -> next cycle IDLE, u_we=0, uni_lock=0.
//     -> then 0x70000000 sets err. With STATS_EN, cmd_count tracks completed commands.

Source files
------------

// File: rtl/gpu_uniform_loader.sv
// gpu_uniform_loader: parses host command words (header + data) and issues
// single-cycle uniform writes for the 4x4 matrix and viewport registers.
// Holds uni_lock from header acceptance until the command completes so the
// pipeline front-end never sees uniforms change under in-flight primitives.
// Optional feature: define UNIFORM_LOADER_STATS_EN to enable the cmd_count
// completed-command counter; otherwise cmd_count is tied to zero.
module gpu_uniform_loader #(
  parameter int unsigned     W        = 32,
  parameter int unsigned     AW       = 8,
  parameter logic [AW-1:0]   MAX_ADDR = AW'(8'h11),
  parameter logic [W-1:0]    FX_ONE   = W'(32'h10000)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [31:0]   cmd_data,
  input  logic          pipe_busy,
  output logic          uni_lock,
  output logic          u_we,
  output logic [AW-1:0] u_addr,
  output logic [W-1:0]  u_data,
  output logic          busy,
  output logic          err,
  input  logic          err_clr,
  output logic [15:0]   cmd_count
);

  localparam int unsigned OPW  = 4;
  localparam int unsigned CNTW = 8;
  localparam int unsigned VPW  = 16;

  localparam logic [OPW-1:0] OP_NOP           = 4'd0;
  localparam logic [OPW-1:0] OP_WRITE_BLOCK   = 4'd1;
  localparam logic [OPW-1:0] OP_SET_VIEWPORT  = 4'd2;
  localparam logic [OPW-1:0] OP_LOAD_IDENTITY = 4'd3;

  localparam logic [AW-1:0] VP_W_ADDR = AW'(8'h10);
  localparam logic [AW-1:0] VP_H_ADDR = AW'(8'h11);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_DATA,
    S_VP,
    S_IDENT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [AW-1:0]   base_q, base_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] idx_q, idx_d;
  logic            vp_hi_q, vp_hi_d;
  logic [VPW-1:0]  vp_word_q, vp_word_d;

  logic            cmd_ready_q, cmd_ready_d;
  logic            uni_lock_q, uni_lock_d;
  logic            busy_q, busy_d;
  logic            u_we_q, u_we_d;
  logic [AW-1:0]   u_addr_q, u_addr_d;
  logic [W-1:0]    u_data_q, u_data_d;
  logic            err_q, err_d;

  logic            accept;
  logic [AW-1:0]   blk_addr;
  logic            wr_req;
  logic [AW-1:0]   wr_a;
  logic [W-1:0]    wr_v;
  logic            err_set;
  logic            hdr_unused;

  // Reserved header bits carry no meaning for this block.
  assign hdr_unused = ^cmd_data[27:16];

  assign accept   = cmd_valid & cmd_ready_q;
  assign blk_addr = base_q + AW'(idx_q);

  // State and registered-output update.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      vp_hi_q     <= 1'b0;
      vp_word_q   <= '0;
      cmd_ready_q <= 1'b1;
      uni_lock_q  <= 1'b0;
      busy_q      <= 1'b0;
      u_we_q      <= 1'b0;
      u_addr_q    <= '0;
      u_data_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      base_q      <= base_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      vp_hi_q     <= vp_hi_d;
      vp_word_q   <= vp_word_d;
      cmd_ready_q <= cmd_ready_d;
      uni_lock_q  <= uni_lock_d;
      busy_q      <= busy_d;
      u_we_q      <= u_we_d;
      u_addr_q    <= u_addr_d;
      u_data_q    <= u_data_d;
      err_q       <= err_d;
    end
  end

  // Next-state, write-request and output decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    vp_hi_d   = vp_hi_q;
    vp_word_d = vp_word_q;
    wr_req    = 1'b0;
    wr_a      = '0;
    wr_v      = '0;
    err_set   = 1'b0;
    u_we_d    = 1'b0;
    u_addr_d  = u_addr_q;
    u_data_d  = u_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_data[31:28];
          base_d  = AW'(cmd_data[15:8]);
          count_d = cmd_data[7:0];
          idx_d   = '0;
          vp_hi_d = 1'b0;
          case (cmd_data[31:28])
            OP_NOP: ;
            OP_WRITE_BLOCK: begin
              if (cmd_data[7:0] != 8'd0) state_d = S_WAIT_IDLE;
            end
            OP_SET_VIEWPORT,
            OP_LOAD_IDENTITY: state_d = S_WAIT_IDLE;
            default: err_set = 1'b1;
          endcase
        end
      end

      S_WAIT_IDLE: begin
        if (!pipe_busy) begin
          case (op_q)
            OP_WRITE_BLOCK:  state_d = S_DATA;
            OP_SET_VIEWPORT: state_d = S_VP;
            default:         state_d = S_IDENT;
          endcase
        end
      end

      S_DATA: begin
        if (accept) begin
          wr_req = 1'b1;
          wr_a   = blk_addr;
          wr_v   = W'(cmd_data);
          idx_d  = idx_q + 8'd1;
          if (idx_d == count_q) state_d = S_DONE;
        end
      end

      S_VP: begin
        // Low half written on acceptance, high half on the following cycle.
        if (!vp_hi_q) begin
          if (accept) begin
            wr_req    = 1'b1;
            wr_a      = VP_W_ADDR;
            wr_v      = W'(cmd_data[15:0]);
            vp_word_d = cmd_data[31:16];
            vp_hi_d   = 1'b1;
          end
        end else begin
          wr_req  = 1'b1;
          wr_a    = VP_H_ADDR;
          wr_v    = W'(vp_word_q);
          vp_hi_d = 1'b0;
          state_d = S_DONE;
        end
      end

      S_IDENT: begin
        wr_req = 1'b1;
        wr_a   = AW'(idx_q[3:0]);
        wr_v   = (idx_q[1:0] == idx_q[3:2]) ? FX_ONE : '0;
        idx_d  = idx_q + 8'd1;
        if (idx_q == 8'd15) state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Out-of-range writes are dropped but the word is still consumed.
    if (wr_req) begin
      if (wr_a > MAX_ADDR) begin
        err_set = 1'b1;
      end else begin
        u_we_d   = 1'b1;
        u_addr_d = wr_a;
        u_data_d = wr_v;
      end
    end

    err_d       = (err_q & ~err_clr) | err_set;
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_DATA) ||
                  ((state_d == S_VP) && !vp_hi_d);
    uni_lock_d  = (state_d != S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign uni_lock  = uni_lock_q;
  assign busy      = busy_q;
  assign u_we      = u_we_q;
  assign u_addr    = u_addr_q;
  assign u_data    = u_data_q;
  assign err       = err_q;

`ifdef UNIFORM_LOADER_STATS_EN
  logic [15:0] cmd_count_q;

  // Completed non-NOP commands; wraps naturally.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cmd_count_q <= '0;
    end else if (state_q == S_DONE) begin
      cmd_count_q <= cmd_count_q + 16'd1;
    end
  end

  assign cmd_count = cmd_count_q;
`else
  assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_gpu_uniform_loader.sv
// Directed bench for gpu_uniform_loader: drives on the falling edge and
// samples on the falling edge, half a cycle after each active edge.
module tb_gpu_uniform_loader;

  logic        CLK = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        pipe_busy;
  logic        uni_lock;
  logic        u_we;
  logic [7:0]  u_addr;
  logic [31:0] u_data;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic [15:0] cmd_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

`ifdef UNIFORM_LOADER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic [31:0] ident_exp [16] = '{
    32'h0001_0000, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0001_0000, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0001_0000, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0001_0000
  };

  always #5 CLK = ~CLK;

  gpu_uniform_loader dut (
    .CLK       (CLK),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .pipe_busy (pipe_busy),
    .uni_lock  (uni_lock),
    .u_we      (u_we),
    .u_addr    (u_addr),
    .u_data    (u_data),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .cmd_count (cmd_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold a word on the bus until it is taken; return on the falling edge after acceptance.
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(cmd_ready), 32'd1);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, 32'(cmd_count), STATS ? 32'(exp_cnt) : 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 32'h0;
    pipe_busy = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);

    // 1: reset state
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_lock",  32'(uni_lock),  32'd0);
    chk("rst_we",    32'(u_we),      32'd0);
    chk("rst_addr",  32'(u_addr),    32'd0);
    chk("rst_data",  u_data,         32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk_cnt("rst_cnt");

    // NOP and zero-length WRITE_BLOCK: no lock, nothing counted
    send(32'h0000_0000);
    chk("nop_lock",  32'(uni_lock),  32'd0);
    chk("nop_ready", 32'(cmd_ready), 32'd1);
    send(32'h1000_0500);
    chk("wb0_lock",  32'(uni_lock),  32'd0);
    chk("wb0_busy",  32'(busy),      32'd0);
    chk("wb0_we",    32'(u_we),      32'd0);

    // 2: WRITE_BLOCK base 5, count 3, with gaps
    send(32'h1000_0503);
    chk("wb_hdr_lock",  32'(uni_lock),  32'd1);
    chk("wb_hdr_ready", 32'(cmd_ready), 32'd0);
    chk("wb_hdr_busy",  32'(busy),      32'd1);
    send(32'hA5A5_0001);
    chk("wb_a_we",   32'(u_we),   32'd1);
    chk("wb_a_addr", 32'(u_addr), 32'h05);
    chk("wb_a_data", u_data,      32'hA5A5_0001);
    @(negedge CLK);
    chk("wb_gap_we",   32'(u_we),     32'd0);
    chk("wb_gap_lock", 32'(uni_lock), 32'd1);
    send(32'hDEAD_BEEF);
    chk("wb_b_we",   32'(u_we),   32'd1);
    chk("wb_b_addr", 32'(u_addr), 32'h06);
    chk("wb_b_data", u_data,      32'hDEAD_BEEF);
    @(negedge CLK);
    @(negedge CLK);
    chk("wb_gap2_we", 32'(u_we), 32'd0);
    send(32'h1234_5678);
    chk("wb_c_we",    32'(u_we),     32'd1);
    chk("wb_c_addr",  32'(u_addr),   32'h07);
    chk("wb_c_data",  u_data,        32'h1234_5678);
    chk("wb_done_lock", 32'(uni_lock), 32'd1);
    exp_cnt++;
    @(negedge CLK);
    chk("wb_end_lock",  32'(uni_lock),  32'd0);
    chk("wb_end_ready", 32'(cmd_ready), 32'd1);
    chk("wb_end_we",    32'(u_we),      32'd0);
    chk_cnt("wb_cnt");

    // 3: LOAD_IDENTITY held off by pipe_busy
    pipe_busy = 1'b1;
    send(32'h3000_0000);
    for (int i = 0; i < 3; i++) begin
      chk("id_wait_lock",  32'(uni_lock),  32'd1);
      chk("id_wait_ready", 32'(cmd_ready), 32'd0);
      chk("id_wait_we",    32'(u_we),      32'd0);
      @(negedge CLK);
    end
    pipe_busy = 1'b0;
    @(negedge CLK);
    chk("id_first_we", 32'(u_we), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk("id_we",   32'(u_we),   32'd1);
      chk("id_addr", 32'(u_addr), 32'(i));
      chk("id_data", u_data,      ident_exp[i]);
    end
    exp_cnt++;
    @(negedge CLK);
    chk("id_end_we",   32'(u_we),     32'd0);
    chk("id_end_lock", 32'(uni_lock), 32'd0);
    chk("id_end_busy", 32'(busy),     32'd0);
    chk_cnt("id_cnt");

    // 4: SET_VIEWPORT
    send(32'h2000_0000);
    chk("vp_hdr_lock", 32'(uni_lock), 32'd1);
    send(32'h00F0_0140);
    chk("vp_w_we",    32'(u_we),      32'd1);
    chk("vp_w_addr",  32'(u_addr),    32'h10);
    chk("vp_w_data",  u_data,         32'h0000_0140);
    chk("vp_w_ready", 32'(cmd_ready), 32'd0);
    @(negedge CLK);
    chk("vp_h_we",   32'(u_we),   32'd1);
    chk("vp_h_addr", 32'(u_addr), 32'h11);
    chk("vp_h_data", u_data,      32'h0000_00F0);
    exp_cnt++;
    @(negedge CLK);
    chk("vp_end_we",   32'(u_we),     32'd0);
    chk("vp_end_lock", 32'(uni_lock), 32'd0);
    chk_cnt("vp_cnt");

    // 5: WRITE_BLOCK running past MAX_ADDR
    send(32'h1000_1003);
    send(32'h1111_0001);
    chk("oor_0_addr", 32'(u_addr), 32'h10);
    chk("oor_0_data", u_data,      32'h1111_0001);
    send(32'h2222_0002);
    chk("oor_1_we",   32'(u_we),   32'd1);
    chk("oor_1_addr", 32'(u_addr), 32'h11);
    chk("oor_1_err",  32'(err),    32'd0);
    send(32'h3333_0003);
    chk("oor_2_we",  32'(u_we), 32'd0);
    chk("oor_2_err", 32'(err),  32'd1);
    exp_cnt++;
    @(negedge CLK);
    chk("oor_sticky", 32'(err),      32'd1);
    chk("oor_idle",   32'(cmd_ready), 32'd1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    chk("errclr", 32'(err), 32'd0);
    chk_cnt("oor_cnt");

    // 6: reset in the middle of LOAD_IDENTITY
    send(32'h3000_0000);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) @(negedge CLK);
    chk("rid_5th_addr", 32'(u_addr), 32'h04);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    exp_cnt = 0;
    chk("rid_we",    32'(u_we),      32'd0);
    chk("rid_lock",  32'(uni_lock),  32'd0);
    chk("rid_ready", 32'(cmd_ready), 32'd1);
    chk("rid_busy",  32'(busy),      32'd0);
    chk_cnt("rid_cnt");
    @(negedge CLK);
    chk("rid_idle_we", 32'(u_we), 32'd0);

    // bad opcode: error, consumed as NOP
    send(32'h7000_0000);
    chk("bad_err",   32'(err),       32'd1);
    chk("bad_lock",  32'(uni_lock),  32'd0);
    chk("bad_ready", 32'(cmd_ready), 32'd1);
    chk_cnt("bad_cnt");

    // err_clr colliding with a new error keeps err set
    err_clr = 1'b1;
    send(32'hF000_0000);
    err_clr = 1'b0;
    chk("clr_vs_set", 32'(err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
